// File: rtl/mult_div_unit_pkg.sv
// Shared HI/LO opcode constants and unit state type.
// Imported by the control unit and the mult/div datapath.
package mult_div_unit_pkg;

  localparam logic [3:0] HL_NONE  = 4'd0;
  localparam logic [3:0] HL_MULT  = 4'd1;
  localparam logic [3:0] HL_MULTU = 4'd2;
  localparam logic [3:0] HL_DIV   = 4'd3;
  localparam logic [3:0] HL_DIVU  = 4'd4;
  localparam logic [3:0] HL_MFLO  = 4'd5;
  localparam logic [3:0] HL_MFHI  = 4'd6;
  localparam logic [3:0] HL_MTLO  = 4'd7;
  localparam logic [3:0] HL_MTHI  = 4'd8;

  typedef enum logic {
    MD_IDLE,
    MD_RUN
  } md_state_t;

  function automatic logic is_md_op(input logic [3:0] op);
    return (op == HL_MULT) || (op == HL_MULTU) ||
           (op == HL_DIV)  || (op == HL_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_md_compute.sv
// Combinational 64-bit {HI,LO} result for mult/multu/div/divu.
// we=0 means the op leaves HI/LO untouched (divide by zero).
module md_compute
  import mult_div_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        we
);

  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        b_safe;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quot_u;
  logic [31:0]        rem_u;
  logic               b_zero;

  assign a_sx   = {{32{a[31]}}, a};
  assign b_sx   = {{32{b[31]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Divisor forced nonzero so the dividers never see x/0.
  assign b_zero = (b == 32'd0);
  assign b_safe = b_zero ? 32'd1 : b;
  assign quot_s = $signed(a) / $signed(b_safe);
  assign rem_s  = $signed(a) % $signed(b_safe);
  assign quot_u = a / b_safe;
  assign rem_u  = a % b_safe;

  always_comb begin
    result = '0;
    we     = 1'b0;
    unique case (1'b1)
      op == HL_MULT: begin
        result = prod_s;
        we     = 1'b1;
      end
      op == HL_MULTU: begin
        result = prod_u;
        we     = 1'b1;
      end
      op == HL_DIV: begin
        result = {rem_s, quot_s};
        we     = !b_zero;
      end
      op == HL_DIVU: begin
        result = {rem_u, quot_u};
        we     = !b_zero;
      end
      default: begin
        result = '0;
        we     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO unit: latches the result at start, then
// holds busy for a fixed cycle count before committing.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  HLOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] HLOut
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  md_state_t   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_we_q, pend_we_d;
  logic [63:0] res;
  logic        res_we;
  logic        is_div;

  md_compute u_md_compute (
    .op     (HLOp),
    .a      (A),
    .b      (B),
    .result (res),
    .we     (res_we)
  );

  assign is_div = (HLOp == HL_DIV) || (HLOp == HL_DIVU);
  assign busy   = (state_q == MD_RUN);
  assign start  = is_md_op(HLOp) && (state_q == MD_IDLE);

  always_comb begin
    HLOut = '0;
    unique case (1'b1)
      HLOp == HL_MFHI: HLOut = hi_q;
      HLOp == HL_MFLO: HLOut = lo_q;
      default:         HLOut = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d   = MD_RUN;
          cnt_d     = is_div ? DIV_CNT : MULT_CNT;
          pend_hi_d = res[63:32];
          pend_lo_d = res[31:0];
          pend_we_d = res_we;
        end else if (HLOp == HL_MTHI) begin
          hi_d = A;
        end else if (HLOp == HL_MTLO) begin
          lo_d = A;
        end
      end
      MD_RUN: begin
        cnt_d = cnt_q - 4'd1;
        // Commit on the last busy cycle; mt/md ops are ignored here.
        if (cnt_q <= 4'd1) begin
          state_d = MD_IDLE;
          cnt_d   = 4'd0;
          if (pend_we_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with hand-computed HI/LO values.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  HLOp = HL_NONE;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        start;
  logic        busy;
  logic [31:0] HLOut;

  int passed = 0;
  int total  = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .HLOp  (HLOp),
    .A     (A),
    .B     (B),
    .start (start),
    .busy  (busy),
    .HLOut (HLOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    HLOp = op;
    A    = a;
    B    = b;
    #1;
  endtask

  task automatic issue(input string tag, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    drive(op, a, b);
    chk({tag, "_start"}, 32'(start), 32'd1);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    tick();
  endtask

  task automatic busy_for(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      drive(HL_NONE, $urandom, $urandom);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_nostart"}, 32'(start), 32'd0);
      tick();
    end
    drive(HL_NONE, 32'd0, 32'd0);
    chk({tag, "_done"}, 32'(busy), 32'd0);
  endtask

  task automatic hilo(input string tag, input logic [31:0] hi,
                      input logic [31:0] lo);
    drive(HL_MFHI, 32'd0, 32'd0);
    chk({tag, "_hi"}, HLOut, hi);
    drive(HL_MFLO, 32'd0, 32'd0);
    chk({tag, "_lo"}, HLOut, lo);
    drive(HL_NONE, 32'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    drive(HL_MTHI, 32'h5555_5555, 32'd0);
    tick();
    drive(HL_MULT, 32'd9, 32'd9);
    chk("rst_nostart_hold", 32'(busy), 32'd0);
    tick();
    reset = 1'b0;
    drive(HL_NONE, 32'd0, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    hilo("rst", 32'd0, 32'd0);

    // mult -2 * 3, operands scrambled after the start edge
    issue("mult", HL_MULT, 32'hFFFF_FFFE, 32'd3);
    busy_for("mult", 5);
    hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // multu with an mflo mid-flight returning the old LO
    issue("multu", HL_MULTU, 32'hFFFF_FFFF, 32'd2);
    drive(HL_NONE, 32'd0, 32'd0);
    chk("multu_b1", 32'(busy), 32'd1);
    tick();
    chk("multu_b2", 32'(busy), 32'd1);
    tick();
    drive(HL_MFLO, 32'd0, 32'd0);
    chk("multu_b3", 32'(busy), 32'd1);
    chk("multu_oldlo", HLOut, 32'hFFFF_FFFA);
    tick();
    busy_for("multu_tail", 2);
    hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

    // signed divide truncating toward zero
    issue("div", HL_DIV, 32'hFFFF_FFF9, 32'd2);
    busy_for("div", 10);
    hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // divu by zero runs full length but leaves HI/LO alone
    issue("divu0", HL_DIVU, 32'd7, 32'd0);
    busy_for("divu0", 10);
    hilo("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // divu with a real divisor
    issue("divu", HL_DIVU, 32'hFFFF_FFFF, 32'd16);
    busy_for("divu", 10);
    hilo("divu", 32'h0000_000F, 32'h0FFF_FFFF);

    // mthi in idle, undefined opcode has no effect
    drive(HL_MTHI, 32'h1234_5678, 32'd0);
    chk("mthi_nostart", 32'(start), 32'd0);
    tick();
    drive(4'hF, 32'hCAFE_F00D, 32'd1);
    chk("undef_start", 32'(start), 32'd0);
    chk("undef_out", HLOut, 32'd0);
    tick();
    hilo("mthi", 32'h1234_5678, 32'h0FFF_FFFF);

    // mtlo and a second mult while busy are both ignored
    issue("mult2", HL_MULT, 32'd2, 32'd3);
    drive(HL_MTLO, 32'hDEAD_BEEF, 32'd0);
    chk("mtlo_busy_start", 32'(start), 32'd0);
    tick();
    drive(HL_MULT, 32'd100, 32'd100);
    chk("mult_busy_start", 32'(start), 32'd0);
    tick();
    busy_for("mult2", 3);
    hilo("mult2", 32'd0, 32'd6);

    // reset in busy cycle 4 of a divide aborts with no commit
    drive(HL_MTHI, 32'h1111_1111, 32'd0);
    tick();
    issue("abort", HL_DIV, 32'd100, 32'd7);
    for (int i = 0; i < 3; i++) begin
      drive(HL_NONE, 32'd0, 32'd0);
      tick();
    end
    reset = 1'b1;
    drive(HL_NONE, 32'd0, 32'd0);
    chk("abort_b4", 32'(busy), 32'd1);
    tick();
    reset = 1'b0;
    drive(HL_NONE, 32'd0, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    hilo("abort", 32'd0, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    chk("abort_late_busy", 32'(busy), 32'd0);
    hilo("abort_late", 32'd0, 32'd0);

    // back-to-back: second mult accepted right after busy falls
    issue("b2b1", HL_MULT, 32'd3, 32'd4);
    busy_for("b2b1", 5);
    issue("b2b2", HL_MULTU, 32'hFFFF_FFFF, 32'd5);
    drive(HL_MFLO, 32'd0, 32'd0);
    chk("b2b_first_lo", HLOut, 32'd12);
    drive(HL_MFHI, 32'd0, 32'd0);
    chk("b2b_first_hi", HLOut, 32'd0);
    tick();
    busy_for("b2b2", 4);
    hilo("b2b2", 32'h0000_0004, 32'hFFFF_FFFB);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
